// File: rtl/uart_pkg.sv
// Shared definitions for the configurable buffered UART transmitter:
// FSM encoding, parity modes and the data-width encoding helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    function automatic logic [3:0] data_bits_count(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] cfg);
        return 8'hFF >> (4'd8 - data_bits_count(cfg));
    endfunction

    // Mode 2'b11 is an alias for "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is visible on dout
// whenever the FIFO is non-empty.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter with run-time frame format (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits) and line-break generation.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        send_break,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BIT_CLKS = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BIT_CLKS);

    tx_state_t  state, state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       stop_more, stop_more_n;
    logic [7:0] frame_data, frame_data_n;
    logic [2:0] frame_last, frame_last_n;
    logic [1:0] frame_par, frame_par_n;
    logic       frame_stop2, frame_stop2_n;
    logic       serial_n;
    logic       load;
    logic       bit_end;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_in_valid),
        .pop   (load),
        .din   (data_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_in_ready = !fifo_full;
    assign tx_busy       = (state != ST_IDLE) || !fifo_empty;
    assign bit_end       = (clk_cnt == CNT_W'(BIT_CLKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_more   <= 1'b0;
            frame_data  <= '0;
            frame_last  <= '0;
            frame_par   <= PAR_NONE;
            frame_stop2 <= 1'b0;
            serial_out  <= 1'b1;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            stop_more   <= stop_more_n;
            frame_data  <= frame_data_n;
            frame_last  <= frame_last_n;
            frame_par   <= frame_par_n;
            frame_stop2 <= frame_stop2_n;
            serial_out  <= serial_n;
        end
    end

    // serial_n is the line level for the coming cycle, so the registered
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        state_n       = state;
        clk_cnt_n     = clk_cnt + CNT_W'(1);
        bit_idx_n     = bit_idx;
        stop_more_n   = stop_more;
        frame_data_n  = frame_data;
        frame_last_n  = frame_last;
        frame_par_n   = frame_par;
        frame_stop2_n = frame_stop2;
        serial_n      = serial_out;
        load          = 1'b0;

        case (state)
            ST_IDLE: begin
                clk_cnt_n = '0;
                serial_n  = 1'b1;
                if (send_break) begin
                    state_n  = ST_BREAK;
                    serial_n = 1'b0;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                    serial_n  = frame_data[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == frame_last) begin
                        if (parity_enabled(frame_par)) begin
                            state_n  = ST_PARITY;
                            serial_n = (^frame_data) ^ (frame_par == PAR_ODD);
                        end else begin
                            state_n     = ST_STOP;
                            stop_more_n = frame_stop2;
                            serial_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        serial_n  = frame_data[bit_idx + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    clk_cnt_n   = '0;
                    state_n     = ST_STOP;
                    stop_more_n = frame_stop2;
                    serial_n    = 1'b1;
                end
            end
            ST_STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (stop_more) begin
                        stop_more_n = 1'b0;
                    end else if (!fifo_empty && !send_break) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                clk_cnt_n = '0;
                serial_n  = 1'b0;
                if (!send_break) begin
                    state_n     = ST_STOP;
                    stop_more_n = 1'b0;
                    serial_n    = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                serial_n = 1'b1;
            end
        endcase

        // Frame format is captured with the byte so later cfg changes only
        // apply to frames that have not yet been popped.
        if (load) begin
            state_n       = ST_START;
            clk_cnt_n     = '0;
            serial_n      = 1'b0;
            frame_data_n  = fifo_head & data_mask(cfg_data_bits);
            frame_last_n  = 3'(data_bits_count(cfg_data_bits) - 4'd1);
            frame_par_n   = cfg_parity;
            frame_stop2_n = cfg_stop2;
        end
    end

endmodule
